// File: rtl/light_sequencer_if.sv
// Control/light bundle for light_sequencer: enable, pattern select, dim duty in; lights out.
interface light_sequencer_if #(
  parameter int unsigned N        = 8,
  parameter int unsigned PWM_BITS = 4
);
  logic                i;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] duty;
  logic [N-1:0]        o;

  modport master (output i, mode, duty, input  o);
  modport slave  (input  i, mode, duty, output o);
endinterface

// File: rtl/light_sequencer.sv
// Pattern generator for N lights: static, chase, blink and PWM dim.
// Any enable drop or mode change restarts the pattern state from zero.
module light_sequencer #(
  parameter int unsigned N        = 8,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  light_sequencer_if.slave bus
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = $clog2(N);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_CHASE  = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_DIM    = 2'b11;

  logic [TW-1:0]       tick_q, tick_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [1:0]          mode_q;
  logic [N-1:0]        o_q, o_d;
  logic                restart_c;
  logic                step_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q  <= '0;
      pos_q   <= '0;
      phase_q <= 1'b1;
      pwm_q   <= '0;
      mode_q  <= MODE_STATIC;
      o_q     <= '0;
    end else begin
      tick_q  <= tick_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
      mode_q  <= bus.mode;
      o_q     <= o_d;
    end
  end

  // Next-state: restart, tick divider, step and free-running PWM counter
  always_comb begin
    tick_d    = tick_q;
    pos_d     = pos_q;
    phase_d   = phase_q;
    pwm_d     = pwm_q;
    step_c    = 1'b0;
    restart_c = !bus.i || (bus.mode != mode_q);
    if (restart_c) begin
      tick_d  = '0;
      pos_d   = '0;
      phase_d = 1'b1;
      pwm_d   = '0;
    end else begin
      pwm_d = pwm_q + PWM_BITS'(1);
      if (tick_q == TW'(TICK_DIV - 1)) begin
        tick_d = '0;
        step_c = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
      if (step_c) begin
        pos_d   = (pos_q == PW'(N - 1)) ? '0 : pos_q + PW'(1);
        phase_d = ~phase_q;
      end
    end
  end

  // Output decode from the post-update state, registered above
  always_comb begin
    o_d = '0;
    if (bus.i) begin
      case (bus.mode)
        MODE_STATIC: o_d = '1;
        MODE_CHASE:  o_d = N'(1) << pos_d;
        MODE_BLINK:  o_d = phase_d ? '1 : '0;
        MODE_DIM:    o_d = (pwm_d < bus.duty) ? '1 : '0;
        default:     o_d = '0;
      endcase
    end
  end

  assign bus.o = o_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: default build plus an N=4, TICK_DIV=1 build.
module tb_light_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  light_sequencer_if #(.N(8), .PWM_BITS(4)) bus_a ();
  light_sequencer_if #(.N(4), .PWM_BITS(4)) bus_b ();

  light_sequencer #(.N(8), .TICK_DIV(4), .PWM_BITS(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  light_sequencer #(.N(4), .TICK_DIV(1), .PWM_BITS(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] onehot(input int unsigned n);
    logic [7:0] v;
    v = 8'h01;
    return v << n;
  endfunction

  // Drive inputs, queue the expected light pattern, compare just after the edge
  task automatic cyc_a(input string tag, input logic en, input logic [1:0] md,
                       input logic [3:0] dt, input logic [7:0] exp);
    logic [7:0] e;
    bus_a.i = en; bus_a.mode = md; bus_a.duty = dt;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk({tag, "_empty"}, 8'hxx, 8'h00);
    else begin
      e = exp_q.pop_front();
      chk(tag, bus_a.o, e);
    end
  endtask

  task automatic cyc_b(input string tag, input logic en, input logic [1:0] md,
                       input logic [7:0] exp);
    logic [7:0] e;
    bus_b.i = en; bus_b.mode = md;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk({tag, "_empty"}, 8'hxx, 8'h00);
    else begin
      e = exp_q.pop_front();
      chk(tag, {4'h0, bus_b.o}, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] d;
    bus_a.i = 1'b0; bus_a.mode = 2'b00; bus_a.duty = 4'h0;
    bus_b.i = 1'b0; bus_b.mode = 2'b00; bus_b.duty = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o", bus_a.o, 8'h00);

    // Static on, then enable drop
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) cyc_a("static_on", 1'b1, 2'b00, 4'h0, 8'hFF);
    for (int k = 1; k <= 2; k++) cyc_a("enable_off", 1'b0, 2'b00, 4'h0, 8'h00);

    // Chase through all positions and wrap
    for (int k = 1; k <= 33; k++)
      cyc_a("chase", 1'b1, 2'b01, 4'h0, onehot(((k - 1) / 4) % 8));

    // Blink, then switch to chase during the off phase
    for (int k = 1; k <= 14; k++)
      cyc_a("blink", 1'b1, 2'b10, 4'h0, (((k - 1) / 4) % 2 == 0) ? 8'hFF : 8'h00);
    for (int k = 1; k <= 5; k++)
      cyc_a("blink_to_chase", 1'b1, 2'b01, 4'h0, onehot((k - 1) / 4));

    // Dim with duty 4, then 0, then 15, changed without restart
    for (int k = 1; k <= 80; k++) begin
      d = (k <= 32) ? 4'd4 : (k <= 48) ? 4'd0 : 4'd15;
      cyc_a("dim", 1'b1, 2'b11, d, (((k - 1) % 16) < int'(d)) ? 8'hFF : 8'h00);
    end

    // Mode change together with enable drop
    cyc_a("mode_and_disable", 1'b0, 2'b00, 4'h0, 8'h00);
    for (int k = 1; k <= 2; k++) cyc_a("static_again", 1'b1, 2'b00, 4'h0, 8'hFF);

    // Chase to position 5, then asynchronous reset mid-cycle
    for (int k = 1; k <= 22; k++)
      cyc_a("chase_pre_rst", 1'b1, 2'b01, 4'h0, onehot((k - 1) / 4));
    rst = 1'b1;
    #1;
    chk("async_rst", bus_a.o, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_held", bus_a.o, 8'h00);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++)
      cyc_a("chase_post_rst", 1'b1, 2'b01, 4'h0, onehot((k - 1) / 4));

    // Small build: step on every edge
    for (int k = 1; k <= 5; k++)
      cyc_b("chase_div1", 1'b1, 2'b01, onehot((k - 1) % 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
